echo_delay_ctrl: RTL and testbench

//  Circular-buffer controller for the echo audio core; sits directly upstream of the SPRAM memory bank.
//  Per input sample it reads the delayed sample, mixes dry + wet output, and writes input + feedback.

---
 rtl/echo_pkg.sv | 18 +
 rtl/echo_sat_mac.sv | 36 +++
 rtl/echo_delay_ctrl.sv | 153 +++++++++++++++
 tb/tb_echo_delay_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// echo_pkg: FSM state encoding and shared constants for the echo delay controller.
package echo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WT,
        CALC,
        WR,
        CLR
    } state_t;

    // Cycles from the accepting sample_valid to the out_valid strobe.
    localparam int ECHO_LAT  = 4;
    // One extra sum bit is enough to see overflow before clamping.
    localparam int SAT_GUARD = 1;

endpackage

// File: rtl/echo_sat_mac.sv
// echo_sat_mac: y = sat(x + (d*gain) >>> GAINW), gain unsigned Q0.GAINW, purely combinational.
module echo_sat_mac
    import echo_pkg::*;
#(
    parameter int BITSIZE = 16,
    parameter int GAINW   = 8
) (
    input  logic signed [BITSIZE-1:0] x,
    input  logic signed [BITSIZE-1:0] d,
    input  logic        [GAINW-1:0]   gain,
    output logic signed [BITSIZE-1:0] y
);

    localparam int PW = BITSIZE + GAINW + 1;
    localparam int SW = BITSIZE + SAT_GUARD;

    logic signed [PW-1:0] d_ext;
    logic signed [PW-1:0] g_ext;
    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] sum;

    assign d_ext = PW'(d);
    assign g_ext = PW'({1'b0, gain});
    assign prod  = d_ext * g_ext;

    // With gain < 1.0 the scaled product fits BITSIZE bits, so SW bits hold the sum exactly.
    assign sum = SW'(PW'(x) + (prod >>> GAINW));

    always_comb begin
        if (sum[SW-1] != sum[SW-2])
            y = sum[SW-1] ? {1'b1, {(BITSIZE-1){1'b0}}} : {1'b0, {(BITSIZE-1){1'b1}}};
        else
            y = sum[BITSIZE-1:0];
    end

endmodule

// File: rtl/echo_delay_ctrl.sv
// echo_delay_ctrl: circular-buffer controller; per sample reads the delayed value, mixes, writes back.
// Define ECHO_CLEAR_EN to zero the whole buffer (one address per clock) after every reset release.
module echo_delay_ctrl
    import echo_pkg::*;
#(
    parameter int BITSIZE = 16,
    parameter int ADDRLEN = 15,
    parameter int GAINW   = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [BITSIZE-1:0] sample_in,
    input  logic               sample_valid,
    input  logic [ADDRLEN-1:0] delay,
    input  logic [GAINW-1:0]   fb_gain,
    input  logic [GAINW-1:0]   wet_gain,
    output logic [BITSIZE-1:0] sample_out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun,
    output logic [ADDRLEN-1:0] mem_addr,
    output logic [BITSIZE-1:0] mem_datain,
    output logic               mem_wren,
    input  logic [BITSIZE-1:0] mem_dataout
);

    state_t                    state;
    state_t                    state_nxt;
    logic [ADDRLEN-1:0]        wr_ptr;
    logic signed [BITSIZE-1:0] x_q;
    logic [ADDRLEN-1:0]        delay_q;
    logic [GAINW-1:0]          fb_q;
    logic [GAINW-1:0]          wet_q;
    logic signed [BITSIZE-1:0] d;
    logic signed [BITSIZE-1:0] wet_y;
    logic signed [BITSIZE-1:0] fb_y;
    logic                      clr_pend;
    logic                      accept;

`ifdef ECHO_CLEAR_EN
    logic clr_done;
    assign clr_pend = ~clr_done;
`else
    assign clr_pend = 1'b0;
`endif

    assign busy   = (state != IDLE) | clr_pend;
    assign accept = sample_valid & ~busy;

    // A zero delay would read back the slot about to be overwritten, so it is muted instead.
    assign d = (delay_q == '0) ? '0 : $signed(mem_dataout);

    echo_sat_mac #(.BITSIZE(BITSIZE), .GAINW(GAINW)) u_wet_mac (
        .x    (x_q),
        .d    (d),
        .gain (wet_q),
        .y    (wet_y)
    );

    echo_sat_mac #(.BITSIZE(BITSIZE), .GAINW(GAINW)) u_fb_mac (
        .x    (x_q),
        .d    (d),
        .gain (fb_q),
        .y    (fb_y)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (clr_pend)          state_nxt = CLR;
                else if (sample_valid) state_nxt = RD;
            end
            RD:   state_nxt = WT;
            WT:   state_nxt = CALC;
            CALC: state_nxt = WR;
            WR:   state_nxt = IDLE;
`ifdef ECHO_CLEAR_EN
            CLR:  if (wr_ptr == '1) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: outputs are registers cleared by the async reset, so mem_wren drops the instant resetn falls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            x_q        <= '0;
            delay_q    <= '0;
            fb_q       <= '0;
            wet_q      <= '0;
            sample_out <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            mem_addr   <= '0;
            mem_datain <= '0;
            mem_wren   <= 1'b0;
`ifdef ECHO_CLEAR_EN
            clr_done   <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            mem_wren  <= 1'b0;
            if (sample_valid && busy) overrun <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (clr_pend) begin
                        mem_addr   <= '0;
                        mem_datain <= '0;
                        mem_wren   <= 1'b1;
                    end else if (accept) begin
                        x_q      <= $signed(sample_in);
                        delay_q  <= delay;
                        fb_q     <= fb_gain;
                        wet_q    <= wet_gain;
                        mem_addr <= wr_ptr - delay;
                    end
                end
                // mem_addr is held through WT and CALC so the registered read data stays stable.
                CALC: begin
                    sample_out <= wet_y;
                    mem_datain <= fb_y;
                    mem_addr   <= wr_ptr;
                    mem_wren   <= 1'b1;
                    out_valid  <= 1'b1;
                end
                WR: wr_ptr <= wr_ptr + ADDRLEN'(1);
`ifdef ECHO_CLEAR_EN
                CLR: begin
                    if (wr_ptr == '1) begin
                        wr_ptr   <= '0;
                        clr_done <= 1'b1;
                    end else begin
                        wr_ptr   <= wr_ptr + ADDRLEN'(1);
                        mem_addr <= wr_ptr + ADDRLEN'(1);
                        mem_wren <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// tb_echo_delay_ctrl: random and directed stimulus against a sample-level echo model with a 1-cycle SPRAM.
module tb_echo_delay_ctrl;

    localparam int BITSIZE = 16;
    localparam int ADDRLEN = 8;
    localparam int GAINW   = 8;
    localparam int N       = 2 ** ADDRLEN;
    localparam int SMAX    = 2 ** (BITSIZE - 1) - 1;
    localparam int SMIN    = -(2 ** (BITSIZE - 1));

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic [BITSIZE-1:0] sample_in = '0;
    logic               sample_valid = 1'b0;
    logic [ADDRLEN-1:0] delay = '0;
    logic [GAINW-1:0]   fb_gain = '0;
    logic [GAINW-1:0]   wet_gain = '0;
    logic [BITSIZE-1:0] sample_out;
    logic               out_valid;
    logic               busy;
    logic               overrun;
    logic [ADDRLEN-1:0] mem_addr;
    logic [BITSIZE-1:0] mem_datain;
    logic               mem_wren;
    logic [BITSIZE-1:0] mem_dataout;

    echo_delay_ctrl #(.BITSIZE(BITSIZE), .ADDRLEN(ADDRLEN), .GAINW(GAINW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .delay        (delay),
        .fb_gain      (fb_gain),
        .wet_gain     (wet_gain),
        .sample_out   (sample_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun),
        .mem_addr     (mem_addr),
        .mem_datain   (mem_datain),
        .mem_wren     (mem_wren),
        .mem_dataout  (mem_dataout)
    );

    always #5 clk = ~clk;

    // SPRAM: read-first, registered output, contents survive reset.
    logic [BITSIZE-1:0] mem [N] = '{default: '0};
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_datain;
        mem_dataout <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model: one entry per accepted sample ----------------
    typedef struct {
        int due;
        int out;
        int wb;
        int waddr;
        int raddr;
        int dly;
    } exp_t;

    exp_t q[$];
    int   ref_buf[N];
    int   ref_wptr   = 0;
    int   last_acc   = -100;
    int   ovr_cycle  = -1;
    int   last_out   = 0;
    int   out_log[$];
    int   wrap_raddr = -1;
    bit   checking   = 1'b0;

    function automatic int sat_mac(input int x, input int d, input int g);
        int s;
        s = x + ((d * g) >>> GAINW);
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        return s;
    endfunction

    task automatic model_reset();
        q.delete();
        ref_wptr  = 0;
        last_acc  = -100;
        ovr_cycle = -1;
        last_out  = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drives one sample_valid cycle; the model decides acceptance from the 5-clock rate rule.
    task automatic send(input int x, input int dly, input int fb, input int wet);
        exp_t e;
        int   d;
        @(posedge clk);
        #1;
        sample_in    = x[BITSIZE-1:0];
        delay        = dly[ADDRLEN-1:0];
        fb_gain      = fb[GAINW-1:0];
        wet_gain     = wet[GAINW-1:0];
        sample_valid = 1'b1;
        if (cyc - last_acc >= 5) begin
            e.raddr  = ((ref_wptr - dly) % N + N) % N;
            d        = (dly == 0) ? 0 : ref_buf[e.raddr];
            e.out    = sat_mac(x, d, wet);
            e.wb     = sat_mac(x, d, fb);
            e.waddr  = ref_wptr;
            e.due    = cyc + 4;
            e.dly    = dly;
            q.push_back(e);
            last_acc = cyc;
        end else if (ovr_cycle < 0) begin
            ovr_cycle = cyc;
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sample_out"}, int'(sample_out), 0);
        check({tag, "_out_valid"},  int'(out_valid),  0);
        check({tag, "_busy"},       int'(busy),       0);
        check({tag, "_overrun"},    int'(overrun),    0);
        check({tag, "_mem_addr"},   int'(mem_addr),   0);
        check({tag, "_mem_datain"}, int'(mem_datain), 0);
        check({tag, "_mem_wren"},   int'(mem_wren),   0);
    endtask

    // ---------------- per-cycle compare ----------------
    exp_t cur;
    bit   due_now;
    bit   exp_busy;

    always @(negedge clk) begin
        if (checking && resetn) begin
            due_now  = 1'b0;
            exp_busy = 1'b0;
            if (q.size() > 0) begin
                cur = q[0];
                if (cyc >= cur.due - 3 && cyc <= cur.due) exp_busy = 1'b1;
                if (cyc == cur.due - 3) begin
                    check("rd_addr", int'(mem_addr), cur.raddr);
                    if (cur.waddr == 0 && cur.dly == 1) wrap_raddr = int'(mem_addr);
                end
                if (cyc >= cur.due) due_now = 1'b1;
            end
            check("busy",      int'(busy),      int'(exp_busy));
            check("overrun",   int'(overrun),   int'(ovr_cycle >= 0 && cyc > ovr_cycle));
            check("out_valid", int'(out_valid), int'(due_now));
            check("mem_wren",  int'(mem_wren),  int'(due_now));
            if (due_now) begin
                check("sample_out", int'($signed(sample_out)), cur.out);
                check("wr_addr",    int'(mem_addr),            cur.waddr);
                check("wr_data",    int'($signed(mem_datain)), cur.wb);
                out_log.push_back(int'($signed(sample_out)));
                ref_buf[cur.waddr] = cur.wb;
                ref_wptr = (ref_wptr + 1) % N;
                last_out = cur.out;
                void'(q.pop_front());
            end else begin
                check("sample_out_hold", int'($signed(sample_out)), last_out);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int exp1 [8];
        int dly;
        exp1 = '{1000, 0, 0, 0, 500, 0, 0, 0};

        idle(2);
        #1;
        check_reset_values("reset");
        resetn = 1'b1;
        model_reset();
        checking = 1'b1;

        // Impulse, delay 4, no feedback, half wet.
        out_log.delete();
        for (int i = 0; i < 8; i++) begin
            send((i == 0) ? 1000 : 0, 4, 0, 128);
            idle(3);
        end
        idle(6);
        for (int i = 0; i < 8; i++) check($sformatf("impulse_out%0d", i), out_log[i], exp1[i]);

        // Decaying echo: delay 2, feedback 0.5, wet ~1.0.
        out_log.delete();
        for (int i = 0; i < 8; i++) begin
            send((i == 0) ? 16000 : 0, 2, 128, 255);
            idle(3);
        end
        idle(6);
        check("decay_s0", out_log[0], 16000);
        check("decay_s1", out_log[1], 0);
        check("decay_s2", out_log[2], 15937);
        check("decay_s4", out_log[4], 7968);
        check("decay_s6", out_log[6], 3984);

        // Saturation in both directions.
        out_log.delete();
        send(SMAX, 1, 0, 255); idle(3);
        send(SMAX, 1, 0, 255); idle(3);
        send(SMIN, 1, 0, 255); idle(3);
        send(SMIN, 1, 0, 255); idle(6);
        check("sat_pos", out_log[1], SMAX);
        check("sat_neg", out_log[3], SMIN);

        // delay == 0 mutes the echo; delay == N-1 reads wr_ptr+1.
        out_log.delete();
        send(1234, 0, 255, 255); idle(3);
        send(-500, N - 1, 64, 200); idle(6);
        check("delay0_out", out_log[0], 1234);

        // Full lap plus three with delay 1: pointer wrap and data continuity.
        wrap_raddr = -1;
        for (int i = 0; i < N + 3; i++) begin
            send(int'($urandom_range(0, 65535)) - 32768, 1,
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            idle(3 + int'($urandom_range(0, 2)));
        end
        idle(6);
        check("wrap_rd_addr", wrap_raddr, N - 1);

        // Second strobe two clocks after the first is dropped and sets overrun.
        check("overrun_before", int'(overrun), 0);
        send(100, 3, 50, 50);
        send(200, 3, 50, 50);
        idle(6);
        check("overrun_after", int'(overrun), 1);

        // Random delays and spacing, some strobes arriving too early.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0:       dly = 0;
                1:       dly = N - 1;
                default: dly = int'($urandom_range(0, N - 1));
            endcase
            send(int'($urandom_range(0, 65535)) - 32768, dly,
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            idle(int'($urandom_range(0, 5)));
        end
        idle(8);

        // Reset asserted during WR aborts the write.
        send(700, 5, 100, 100);
        idle(2);
        @(posedge clk);
        #1;
        check("wr_state_wren", int'(mem_wren), 1);
        checking = 1'b0;
        resetn   = 1'b0;
        #1;
        check_reset_values("midreset");
        q.delete();
        idle(2);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
        checking = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(321 * (i + 1), 1, 128, 255);
            idle(3);
        end
        idle(8);
        check("drain", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
